frame_reader: RTL and testbench
===============================

// Module: frame_reader
// PURPOSE
//  Downstream of multi_solver. Once all solvers report done, walks the 640x480
//  frame in raster order and computes each pixel's (solver id, RAM address).
//  Issues the read through multi_solver's rd_solver_id/rd_addr port, captures
//  the 4-bit iteration result and hands each pixel to the display/output stage
//  over a valid/ready stream. Mapping: pixel p -> solver p % NUM_SOLVERS,
//  addr p / NUM_SOLVERS. Both values come from wrap counters; no divider.
// PARAMETERS
//  NUM_SOLVERS  1    solver count; must match multi_solver, range 1..64
//  WIDTH        640  pixels per line
//  HEIGHT       480  lines per frame
// PORTS
//  clock        in   1   single clock domain
//  reset        in   1   synchronous, ACTIVE-LOW (reset==0 resets on posedge)
//  start        in   1   request one frame; sampled only in IDLE
//  solvers_done in   1   multi_solver done
//  rd_solver_id out  6   solver select to multi_solver
//  rd_addr      out  19  per-solver RAM address
//  rd_data_in   in   4   signed; multi_solver rd_data_out
//  pix_valid    out  1   output pixel valid
//  pix_ready    in   1   downstream accepts pixel
//  pix_data     out  8   pixel value (see CONFIGURATION)
//  pix_x        out  10  column of the current pixel
//  pix_y        out  9   row of the current pixel
//  pix_sof      out  1   high with pixel (0,0)
//  pix_eol      out  1   high with pixel x==WIDTH-1
//  busy         out  1   high in any state other than IDLE
//  frame_done   out  1   one-cycle pulse after the last pixel is accepted
// BEHAVIOUR
//  - Reset: all outputs 0. State IDLE. Counters (x, y, id, addr) cleared.
//  - FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> PRESENT -> (ISSUE | DONE) -> IDLE.
//  - IDLE: when start && solvers_done, go to ISSUE. If start arrives while
//    solvers_done==0, it is held pending until solvers_done rises.
//  - ISSUE: rd_solver_id/rd_addr are registered outputs. They are already valid
//    for the current pixel and stay stable through WAIT and CAPTURE, because
//    multi_solver muxes its registered RAM output by rd_solver_id.
//  - WAIT: one cycle for the RAM read register.
//  - CAPTURE: latch rd_data_in into the output register, set pix_valid.
//  - PRESENT: hold pix_valid and all pix_* stable until pix_ready==1.
//    On accept: advance the counters.
//      * id == NUM_SOLVERS-1 -> id=0, addr+1; otherwise id+1.
//      * x == WIDTH-1 -> x=0, y+1.
//    Then go to ISSUE, or to DONE if the accepted pixel was the last one.
//  - Latency: 3 cycles from entering ISSUE to pix_valid.
//    Minimum rate: 1 pixel / 4 cycles.
//  - DONE: pulse frame_done for one cycle; clear all counters; return to IDLE.
//  - Abort: if solvers_done falls in any non-IDLE state, the abort wins over a
//    same-cycle pix_ready. Next cycle: pix_valid=0, counters cleared, state
//    IDLE, no frame_done.
//  - A valid pixel is never changed or dropped while pix_valid=1 && pix_ready=0,
//    except on abort or reset.
//  - Reset (reset==0) mid-frame: same as the reset state; any pending start is
//    discarded.
//  - pix_sof = (x==0 && y==0). pix_eol = (x==WIDTH-1). Both are registered with
//    pix_valid.
// CONFIGURATION
//  PALETTE_EN defined:
//    pix_data = registered 16-entry lookup indexed by rd_data_in[3:0].
//    Entry 0xF (-1, "in set") = 8'h00. Entry k = {k[3:0], 4'hF} for k in 0..14.
//    Lookup latency is absorbed in CAPTURE; overall latency is unchanged.
//  PALETTE_EN undefined:
//    pix_data = {{4{rd_data_in[3]}}, rd_data_in}, i.e. sign-extended raw value.
// TESTING
//  1 NUM_SOLVERS=4, model RAM filled with (p%16); start with solvers_done=1
//    -> pixel 5 reads id=1 addr=1; pixel 640 reads id=0 addr=160; every
//    pix_data matches the model.
//  2 pix_ready held 0 for 10 cycles on pixel 3 -> pix_* are stable for all
//    10 cycles, then pixel 4 follows with correct x=4.
//  3 Full frame with pix_ready=1 -> exactly 307200 pixels, 480 eol, 1 sof,
//    one frame_done pulse, last pixel x=639 y=479.
//  4 start while solvers_done=0, solvers_done rises 20 cycles later -> busy
//    rises on the next cycle; first read is id=0 addr=0.
//  5 solvers_done drops at pixel 1000 -> pix_valid=0 the next cycle, state
//    IDLE, no frame_done; the next start begins at (0,0).
//  6 reset=0 mid-PRESENT -> all outputs 0 the next cycle. With PALETTE_EN,
//    rd_data_in=-1 -> pix_data=8'h00, and 3 -> 8'h3F.

Source files
------------

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - raster-order reader of multi_solver results onto a pixel stream
// Optional build macro PALETTE_EN selects a 16-entry colour lookup for pix_data.
module frame_reader #(
  parameter int NUM_SOLVERS = 1,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        solvers_done,
  output logic [5:0]  rd_solver_id,
  output logic [18:0] rd_addr,
  input  logic [3:0]  rd_data_in,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [5:0] ID_LAST = 6'(NUM_SOLVERS - 1);
  localparam logic [9:0] X_LAST  = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST  = 9'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        pending;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [5:0]  id;
  logic [18:0] addr;
  logic [7:0]  pix_value;

  logic go;
  logic abort;
  logic accept;
  logic last_pix;
  logic capture;
  logic advance;
  logic clear_cnt;

  // Read address is the live counter pair; it only moves on accept, so it stays
  // stable across ISSUE, WAIT and CAPTURE as multi_solver's output mux requires.
  assign rd_solver_id = id;
  assign rd_addr      = addr;
  assign busy         = (state != S_IDLE);

  assign go        = (start | pending) & solvers_done;
  assign abort     = (state != S_IDLE) & ~solvers_done;
  assign last_pix  = (x == X_LAST) & (y == Y_LAST);
  assign accept    = (state == S_PRESENT) & pix_ready & ~abort;
  assign capture   = (state == S_CAPTURE) & ~abort;
  assign advance   = accept & ~last_pix;
  assign clear_cnt = abort | (state == S_DONE) | (accept & last_pix);

`ifdef PALETTE_EN
  always_comb begin
    pix_value = {rd_data_in, 4'hF};
    if (rd_data_in == 4'hF) begin
      pix_value = 8'h00;
    end
  end
`else
  assign pix_value = {{4{rd_data_in[3]}}, rd_data_in};
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (go) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_PRESENT;
      S_PRESENT: if (pix_ready) state_next = last_pix ? S_DONE : S_ISSUE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending    <= 1'b0;
      x          <= '0;
      y          <= '0;
      id         <= '0;
      addr       <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A start seen while the solvers are still running is remembered until done.
      if (state == S_IDLE) begin
        pending <= (start | pending) & ~solvers_done;
      end else begin
        pending <= 1'b0;
      end

      if (clear_cnt) begin
        x    <= '0;
        y    <= '0;
        id   <= '0;
        addr <= '0;
      end else if (advance) begin
        if (id == ID_LAST) begin
          id   <= '0;
          addr <= addr + 19'd1;
        end else begin
          id <= id + 6'd1;
        end
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 9'd1;
        end else begin
          x <= x + 10'd1;
        end
      end

      if (abort) begin
        pix_valid <= 1'b0;
      end else if (capture) begin
        pix_valid <= 1'b1;
        pix_data  <= pix_value;
        pix_x     <= x;
        pix_y     <= y;
        pix_sof   <= (x == '0) & (y == '0);
        pix_eol   <= (x == X_LAST);
      end else if (accept) begin
        pix_valid <= 1'b0;
        if (last_pix) begin
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - scoreboard bench for frame_reader on a reduced 16x8 frame
module tb_frame_reader;

  localparam int NS = 4;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int NPIX = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        solvers_done = 1'b0;
  logic [5:0]  rd_solver_id;
  logic [18:0] rd_addr;
  logic [3:0]  rd_data_in = 4'h0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [7:0]  pix_data;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic        busy;
  logic        frame_done;

  frame_reader #(.NUM_SOLVERS(NS), .WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .start(start), .solvers_done(solvers_done),
    .rd_solver_id(rd_solver_id), .rd_addr(rd_addr), .rd_data_in(rd_data_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // multi_solver stand-in: registered RAM read, pixel p holds p % 16
  always @(posedge clock)
    rd_data_in <= 4'((int'(rd_addr) * NS + int'(rd_solver_id)) % 16);

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  d;
    logic        sof;
    logic        eol;
    logic [5:0]  id;
    logic [18:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0, eol_cnt = 0, sof_cnt = 0, fd_cnt = 0;
  logic [9:0] last_x = '0;
  logic [8:0] last_y = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pix(int v);
    logic [3:0] k;
    k = 4'(v % 16);
`ifdef PALETTE_EN
    return (k == 4'hF) ? 8'h00 : {k, 4'hF};
`else
    return {{4{k[3]}}, k};
`endif
  endfunction

  task automatic push_frame(int n);
    exp_t t;
    for (int p = 0; p < n; p++) begin
      t.x    = 10'(p % W);
      t.y    = 9'(p / W);
      t.d    = exp_pix(p);
      t.sof  = (p == 0);
      t.eol  = ((p % W) == W - 1);
      t.id   = 6'(p % NS);
      t.addr = 19'(p / NS);
      sb.push_back(t);
    end
  endtask

  // Monitor: an accepted pixel is valid && ready with no same-cycle abort.
  always @(negedge clock) begin
    if (frame_done) fd_cnt++;
    if (reset && pix_valid && pix_ready && solvers_done) begin
      acc_cnt++;
      if (pix_eol) eol_cnt++;
      if (pix_sof) sof_cnt++;
      last_x = pix_x;
      last_y = pix_y;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d expected none", pix_x, pix_y);
      end else begin
        e = sb.pop_front();
        check("pix_x", 64'(pix_x), 64'(e.x));
        check("pix_y", 64'(pix_y), 64'(e.y));
        check("pix_data", 64'(pix_data), 64'(e.d));
        check("pix_sof", 64'(pix_sof), 64'(e.sof));
        check("pix_eol", 64'(pix_eol), 64'(e.eol));
        check("rd_solver_id", 64'(rd_solver_id), 64'(e.id));
        check("rd_addr", 64'(rd_addr), 64'(e.addr));
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pixel(input int px, input int py, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pix_valid && int'(pix_x) == px && int'(pix_y) == py) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (frame_done) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  logic [63:0] snap;
  int a0, e0, s0, f0;
  bit ok;

  initial begin
    repeat (3) tick();
    check("reset_outputs", 64'({pix_valid, busy, frame_done, rd_solver_id, rd_addr,
                                pix_data, pix_x, pix_y, pix_sof, pix_eol}), 64'(0));
    reset = 1'b1;
    solvers_done = 1'b1;
    tick();

    // Frame 1: mapping, stall at pixel 3, full-frame statistics
    a0 = acc_cnt; e0 = eol_cnt; s0 = sof_cnt; f0 = fd_cnt;
    push_frame(NPIX);
    pulse_start();
    wait_pixel(3, 0, ok);
    check("reach_pixel3", 64'(ok), 64'(1));
    pix_ready = 1'b0;
    snap = 64'({pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_stable", 64'({pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol}), snap);
    end
    pix_ready = 1'b1;
    wait_pixel(5, 0, ok);
    check("reach_pixel5", 64'(ok), 64'(1));
    check("pixel5_id", 64'(rd_solver_id), 64'(1));
    check("pixel5_addr", 64'(rd_addr), 64'(1));
    wait_pixel(0, 4, ok);
    check("reach_pixel64", 64'(ok), 64'(1));
    check("pixel64_id", 64'(rd_solver_id), 64'(0));
    check("pixel64_addr", 64'(rd_addr), 64'(16));
    wait_done(ok);
    check("frame1_done_seen", 64'(ok), 64'(1));
    tick();
    tick();
    check("frame1_pixels", 64'(acc_cnt - a0), 64'(NPIX));
    check("frame1_eol", 64'(eol_cnt - e0), 64'(H));
    check("frame1_sof", 64'(sof_cnt - s0), 64'(1));
    check("frame1_done_pulses", 64'(fd_cnt - f0), 64'(1));
    check("frame1_last_xy", 64'({last_x, last_y}), 64'({10'd15, 9'd7}));
    check("frame1_sb_empty", 64'(sb.size()), 64'(0));
    check("frame1_idle", 64'(busy), 64'(0));

    // Pending start, then abort at pixel 100
    solvers_done = 1'b0;
    pulse_start();
    repeat (20) tick();
    check("pending_not_busy", 64'(busy), 64'(0));
    solvers_done = 1'b1;
    tick();
    check("pending_busy", 64'(busy), 64'(1));
    check("pending_first_read", 64'({rd_solver_id, rd_addr}), 64'(0));
    a0 = acc_cnt; f0 = fd_cnt;
    push_frame(100);
    wait_pixel(4, 6, ok);
    check("reach_pixel100", 64'(ok), 64'(1));
    solvers_done = 1'b0;
    tick();
    check("abort_valid", 64'(pix_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_counters", 64'({rd_solver_id, rd_addr}), 64'(0));
    repeat (5) tick();
    check("abort_no_done", 64'(fd_cnt - f0), 64'(0));
    check("abort_pixels", 64'(acc_cnt - a0), 64'(100));
    check("abort_sb_empty", 64'(sb.size()), 64'(0));

    // Restart after abort begins at (0,0)
    solvers_done = 1'b1;
    a0 = acc_cnt; s0 = sof_cnt; f0 = fd_cnt;
    push_frame(NPIX);
    pulse_start();
    wait_done(ok);
    check("frame2_done_seen", 64'(ok), 64'(1));
    tick();
    tick();
    check("frame2_pixels", 64'(acc_cnt - a0), 64'(NPIX));
    check("frame2_sof", 64'(sof_cnt - s0), 64'(1));
    check("frame2_done_pulses", 64'(fd_cnt - f0), 64'(1));
    check("frame2_sb_empty", 64'(sb.size()), 64'(0));

    // Reset while presenting pixel 0
    pix_ready = 1'b0;
    pulse_start();
    wait_pixel(0, 0, ok);
    check("reach_present", 64'(ok), 64'(1));
    check("present_data", 64'(pix_data), 64'(exp_pix(0)));
    reset = 1'b0;
    tick();
    check("midreset_outputs", 64'({pix_valid, busy, frame_done, rd_solver_id, rd_addr,
                                   pix_data, pix_x, pix_y, pix_sof, pix_eol}), 64'(0));
    reset = 1'b1;
    pix_ready = 1'b1;
    repeat (10) tick();
    check("post_reset_idle", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
